zmod_tx_framer: RTL and testbench
=================================

// Module: zmod_tx_framer
// PURPOSE
// Transmit-side framer for the zmod LVDS link: turns a valid/ready word stream into per-divclk
// parallel words for the N data-lane OSERDESE3s plus the fixed sync-lane word. Runs on txdivclk.
// Sends a training counter after reset or on request, so the receiver gearbox can align and check.
// Otherwise it sends length-prefixed, checksummed frames separated by idle words.
// PARAMETERS
// N_LANES      3     number of data lanes; word width W = 8*N_LANES
// MAX_LEN      256   largest payload length in words that the framer accepts
// TRAIN_WORDS  1024  number of counter words sent in one training burst
// PORTS
// clk          in   1        tx divided clock (txdivclk), drives the OSERDES CLKDIV
// rst          in   1        synchronous, active-high reset
// train_req    in   1        pulse: request a training burst
// s_data       in   W        payload word
// s_valid      in   1        s_data valid
// s_sof        in   1        first beat of a frame
// s_len        in   16       payload length in words; sampled only on the SOF beat
// s_ready      out  1        beat accepted when s_valid & s_ready
// lane_d       out  N_LANES x 8  parallel words to data-lane OSERDES (packed [N_LANES-1:0][7:0])
// sync_d       out  8        word to sync-lane OSERDES; constant 8'b0000_0001
// training     out  1        high while a training burst is being sent
// frame_cnt    out  16       frames completed, wraps at 2^16
// underrun     out  1        sticky: s_valid was low during PAYLOAD
// len_err      out  1        sticky: SOF arrived with s_len > MAX_LEN
// BEHAVIOUR
// - Reset: all outputs registered. lane_d = IDLE_WORD (24'h5A5A5A), training = 0, frame_cnt = 0,
//   underrun = 0, len_err = 0, state = TRAIN with counter = 0.
// - sync_d = SYNC_WORD in every cycle, including reset.
// - Latency: a beat accepted in cycle t appears on lane_d in cycle t+1.
// - States: TRAIN, IDLE, HDR, PAYLOAD, CKSUM.
// - TRAIN: lane_d = 24-bit counter, starting at 0 and incrementing by 1 each cycle.
//   After TRAIN_WORDS words, go to IDLE. training = 1 throughout. s_ready = 0.
// - IDLE: lane_d = IDLE_WORD. s_ready = ~s_sof.
//   A beat with s_valid & ~s_sof is dropped, because it is orphaned.
//   On s_valid & s_sof with 1 <= s_len <= MAX_LEN: latch s_len, go to HDR. The SOF beat is not consumed.
//   On s_valid & s_sof with s_len = 0: go to HDR, then straight to CKSUM.
//   On s_valid & s_sof with s_len > MAX_LEN: set len_err, hold s_ready = 1 for one cycle to drop
//   the beat, stay in IDLE.
// - HDR: lane_d = {HDR_MARK 8'hA5, len[15:0]}, with lane N-1 carrying the marker. s_ready = 0.
//   Next state is PAYLOAD.
// - PAYLOAD: s_ready = 1. Each accepted beat goes to lane_d, sum += s_data (mod 2^W), remaining -= 1.
//   After the last beat, go to CKSUM.
//   If s_valid = 0: set underrun, send IDLE_WORD, abort to IDLE. The receiver then sees a checksum or
//   framing error. Remaining beats are dropped in IDLE.
// - CKSUM: lane_d = sum, then sum is cleared and frame_cnt increments. Next state is IDLE, or TRAIN
//   if a train request is pending.
// - train_req: in IDLE it takes effect on the next cycle. In HDR/PAYLOAD/CKSUM it is latched as
//   pending and honoured after CKSUM. In TRAIN it restarts the counter at 0. A pending request
//   survives an abort and is honoured from IDLE.
// - rst mid-frame: abandons the frame immediately. No checksum is sent. Sticky flags clear.
// - Counter and frame_cnt wrap silently.
// STRUCTURE
// - Package zmod_pkg holds: SYNC_WORD = 8'b0000_0001, IDLE_WORD, HDR_MARK = 8'hA5,
//   and typedef enum framer_state_t {TRAIN, IDLE, HDR, PAYLOAD, CKSUM}.
// - One sub-module, zmod_tx_train_gen: the 24-bit training counter with clear/enable and a
//   done pulse at TRAIN_WORDS.
// - The remaining logic (FSM, checksum accumulator, length counter) lives in zmod_tx_framer.
// TESTING
// 1. Release rst, TRAIN_WORDS = 16 -> lane_d = 0,1,...,15 on consecutive cycles with training = 1,
//    then IDLE_WORD; sync_d = 8'h01 throughout.
// 2. SOF with s_len = 3, data 24'h000001, 24'h000010, 24'h000100, no gaps ->
//    lane_d = A50003, 000001, 000010, 000100, 000111, IDLE; frame_cnt = 1.
// 3. s_len = 4 with s_valid low on the 3rd beat -> underrun = 1; IDLE_WORD in that cycle;
//    the trailing beat is dropped with s_ready = 1; frame_cnt unchanged.
// 4. s_len = 300 with MAX_LEN = 256 -> len_err = 1; beat dropped; lane_d stays IDLE_WORD.
// 5. train_req pulsed mid-PAYLOAD -> the frame completes including its checksum,
//    then a training burst starts from 0.
// 6. s_len = 0 -> A50000 then 000000; frame_cnt increments. Also: rst asserted in PAYLOAD ->
//    next cycle lane_d = IDLE_WORD and the training burst restarts.

Source files
------------

// File: rtl/zmod_pkg.sv
// Shared constants and state type for the zmod transmit path.
// Holds link words (sync, idle, header marker) and the framer state enum.
package zmod_pkg;

    localparam logic [7:0]  SYNC_WORD = 8'b0000_0001;
    localparam logic [7:0]  IDLE_BYTE = 8'h5A;
    localparam logic [23:0] IDLE_WORD = {3{IDLE_BYTE}};
    localparam logic [7:0]  HDR_MARK  = 8'hA5;

    typedef enum logic [2:0] {
        TRAIN,
        IDLE,
        HDR,
        PAYLOAD,
        CKSUM
    } framer_state_t;

endpackage

// File: rtl/zmod_tx_train_gen.sv
// Training counter for the zmod tx framer.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (advance),
// count (24-bit training word), done (last word of a burst this cycle).
module zmod_tx_train_gen #(
    parameter int TRAIN_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [23:0] count,
    output logic        done
);

    assign done = en & (count == 24'(TRAIN_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 24'd1;
        end
    end

endmodule

// File: rtl/zmod_tx_framer.sv
// Transmit framer for the zmod LVDS link: training bursts, then length-
// prefixed checksummed frames separated by idle words.
// Ports: clk, rst (sync, active-high), train_req, s_data/s_valid/s_sof/s_len
// in, s_ready out; lane_d (data lanes), sync_d, training, frame_cnt,
// underrun and len_err (sticky) out.
module zmod_tx_framer
    import zmod_pkg::*;
#(
    parameter int N_LANES     = 3,
    parameter int MAX_LEN     = 256,
    parameter int TRAIN_WORDS = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    train_req,
    input  logic [8*N_LANES-1:0]    s_data,
    input  logic                    s_valid,
    input  logic                    s_sof,
    input  logic [15:0]             s_len,
    output logic                    s_ready,
    output logic [N_LANES-1:0][7:0] lane_d,
    output logic [7:0]              sync_d,
    output logic                    training,
    output logic [15:0]             frame_cnt,
    output logic                    underrun,
    output logic                    len_err
);

    localparam int W = 8 * N_LANES;
    localparam logic [W-1:0] IDLE_W = {N_LANES{IDLE_BYTE}};

    framer_state_t state, state_nx;

    logic [15:0]  rem, rem_nx;
    logic [W-1:0] sum, sum_nx;
    logic [W-1:0] lane_nx, hdr_w;
    logic         pend, pend_nx;
    logic         urun_set, lerr_set, cnt_inc;
    logic         oversize;
    logic         tg_clr, tg_en, tg_done;
    logic [23:0]  tg_count;

    zmod_tx_train_gen #(
        .TRAIN_WORDS(TRAIN_WORDS)
    ) u_train (
        .clk  (clk),
        .rst  (rst),
        .clr  (tg_clr),
        .en   (tg_en),
        .count(tg_count),
        .done (tg_done)
    );

    assign sync_d   = SYNC_WORD;
    assign oversize = {1'b0, s_len} > 17'(MAX_LEN);
    // Marker rides on the top lane, length in the low 16 bits.
    assign hdr_w    = W'(rem) | (W'(HDR_MARK) << (W - 8));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TRAIN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        sum_nx   = sum;
        lane_nx  = IDLE_W;
        pend_nx  = pend;
        urun_set = 1'b0;
        lerr_set = 1'b0;
        cnt_inc  = 1'b0;
        s_ready  = 1'b0;
        tg_en    = 1'b0;
        tg_clr   = 1'b1;
        unique case (state)
            TRAIN: begin
                tg_en   = 1'b1;
                tg_clr  = train_req;
                lane_nx = W'(tg_count);
                if (!train_req && tg_done) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                // Orphan beats are swallowed; an oversize SOF is swallowed too.
                s_ready = ~s_sof | (s_valid & oversize);
                if (s_valid && s_sof) begin
                    if (oversize) begin
                        lerr_set = 1'b1;
                    end else begin
                        rem_nx   = s_len;
                        state_nx = HDR;
                    end
                end
                if (train_req || pend) begin
                    state_nx = TRAIN;
                end
            end
            HDR: begin
                lane_nx  = hdr_w;
                sum_nx   = '0;
                pend_nx  = pend | train_req;
                state_nx = (rem == 16'd0) ? CKSUM : PAYLOAD;
            end
            PAYLOAD: begin
                s_ready = 1'b1;
                pend_nx = pend | train_req;
                if (s_valid) begin
                    lane_nx = s_data;
                    sum_nx  = sum + s_data;
                    rem_nx  = rem - 16'd1;
                    if (rem == 16'd1) begin
                        state_nx = CKSUM;
                    end
                end else begin
                    urun_set = 1'b1;
                    state_nx = IDLE;
                end
            end
            CKSUM: begin
                lane_nx  = sum;
                sum_nx   = '0;
                cnt_inc  = 1'b1;
                state_nx = (pend || train_req) ? TRAIN : IDLE;
            end
            default: begin
                state_nx = TRAIN;
            end
        endcase
        if (state_nx == TRAIN) begin
            pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_d    <= IDLE_W;
            training  <= 1'b0;
            frame_cnt <= '0;
            underrun  <= 1'b0;
            len_err   <= 1'b0;
            rem       <= '0;
            sum       <= '0;
            pend      <= 1'b0;
        end else begin
            lane_d    <= lane_nx;
            training  <= (state == TRAIN);
            frame_cnt <= frame_cnt + 16'(cnt_inc);
            underrun  <= underrun | urun_set;
            len_err   <= len_err | lerr_set;
            rem       <= rem_nx;
            sum       <= sum_nx;
            pend      <= pend_nx;
        end
    end

endmodule

// File: tb/tb_zmod_tx_framer.sv
// Randomized bench for zmod_tx_framer: scenario driver plus a
// transaction-level model of the non-idle word stream and the flags.
module tb_zmod_tx_framer;

    localparam logic [23:0] IDLE_W = 24'h5A5A5A;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            train_req;
    logic [23:0]     s_data;
    logic            s_valid;
    logic            s_sof;
    logic [15:0]     s_len;
    logic            s_ready;
    logic [2:0][7:0] lane_d;
    logic [7:0]      sync_d;
    logic            training;
    logic [15:0]     frame_cnt;
    logic            underrun;
    logic            len_err;
    logic [23:0]     lane_w;

    int n_tests = 0;
    int n_fail  = 0;
    int sync_bad = 0;
    int m_frames = 0;
    bit m_urun = 0;
    bit m_lerr = 0;

    logic [31:0] obs[$];
    logic [31:0] expq[$];
    logic [23:0] fd[$];

    assign lane_w = lane_d;

    zmod_tx_framer #(
        .N_LANES(3),
        .MAX_LEN(256),
        .TRAIN_WORDS(TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .train_req(train_req),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_sof    (s_sof),
        .s_len    (s_len),
        .s_ready  (s_ready),
        .lane_d   (lane_d),
        .sync_d   (sync_d),
        .training (training),
        .frame_cnt(frame_cnt),
        .underrun (underrun),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sync_d !== 8'h01) sync_bad++;
        if (lane_w !== IDLE_W) obs.push_back({7'd0, training, lane_w});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_train();
        for (int i = 0; i < TW; i++) expq.push_back({8'd1, 24'(i)});
    endtask

    task automatic end_checks();
        @(negedge clk);
        chk("underrun", 32'(underrun), 32'(m_urun));
        chk("len_err", 32'(len_err), 32'(m_lerr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    endtask

    // mode 0: complete frame, 1: s_valid low at beat k, 2: rst at beat k.
    // tr >= 0 pulses train_req while beat tr is offered.
    task automatic send_frame(input int len, input int mode, input int k,
                              input int tr, input bit fixed);
        logic [23:0] s;
        logic [23:0] pd;
        int nacc;
        int n;
        bit ok;
        bit pc;
        nacc = (mode == 0) ? len : k;
        if (!fixed) begin
            do begin
                fd.delete();
                s = '0;
                ok = 1;
                for (int i = 0; i < len; i++) begin
                    fd.push_back(24'($urandom));
                    if (fd[i] == IDLE_W) ok = 0;
                    if (i < nacc) s += fd[i];
                end
            end while (!ok || (mode == 0 && s == IDLE_W));
        end else begin
            s = '0;
            foreach (fd[i]) s += fd[i];
        end
        expq.push_back({8'd0, 8'hA5, 16'(len)});
        for (int i = 0; i < nacc; i++) expq.push_back({8'd0, fd[i]});
        if (mode == 0) begin
            expq.push_back({8'd0, s});
            m_frames++;
        end
        if (mode == 1) m_urun = 1;
        if (mode == 2) begin
            m_frames = 0;
            m_urun = 0;
            m_lerr = 0;
        end
        if (tr >= 0 || mode == 2) push_train();

        @(posedge clk); #1;
        pc = 0;
        pd = '0;
        for (int i = 0; i < len; i++) begin
            if (mode != 0 && i == k) begin
                s_valid = 0;
                train_req = 0;
                if (mode == 2) rst = 1;
                @(negedge clk);
                if (pc) chk("lat", 32'(lane_w), 32'(pd));
                pc = 0;
                @(posedge clk); #1;
                rst = 0;
                @(negedge clk);
                chk("abort_idle", 32'(lane_w), 32'(IDLE_W));
                if (mode == 1) begin
                    chk("urun_flag", 32'(underrun), 32'd1);
                    chk("urun_fcnt", 32'(frame_cnt), 32'(m_frames));
                end else begin
                    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
                    chk("rst_urun", 32'(underrun), 32'd0);
                    chk("rst_train", 32'(training), 32'd0);
                end
                @(posedge clk); #1;
                if (mode == 2) break;
            end
            s_valid = 1;
            s_sof = (i == 0);
            s_data = fd[i];
            s_len = 16'(len);
            train_req = (i == tr);
            @(negedge clk);
            if (pc) chk("lat", 32'(lane_w), 32'(pd));
            pc = 0;
            n = 0;
            while (!s_ready && n < 100) begin
                @(posedge clk); #1;
                train_req = 0;
                @(negedge clk);
                n++;
            end
            if (!s_ready) begin
                chk("rdy_timeout", 32'(s_ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
            train_req = 0;
            if (mode == 0 || i < k) begin
                pc = 1;
                pd = fd[i];
            end
        end
        s_valid = 0;
        s_sof = 0;
        train_req = 0;
        if (pc) begin
            @(negedge clk);
            chk("lat", 32'(lane_w), 32'(pd));
        end
        if (mode == 0) begin
            @(negedge clk);
            chk("cksum", 32'(lane_w), 32'(s));
        end
        repeat ((tr >= 0 || mode == 2) ? 20 : 3) @(posedge clk);
        end_checks();
    endtask

    task automatic send_len0();
        @(posedge clk); #1;
        s_valid = 1;
        s_sof = 1;
        s_len = 16'd0;
        s_data = 24'($urandom);
        @(negedge clk);
        chk("len0_rdy", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_valid = 0;
        s_sof = 0;
        expq.push_back(32'h00A50000);
        expq.push_back(32'h0);
        m_frames++;
        @(negedge clk);
        @(negedge clk);
        chk("len0_hdr", 32'(lane_w), 32'h00A50000);
        @(negedge clk);
        chk("len0_ck", 32'(lane_w), 32'h0);
        repeat (3) @(posedge clk);
        end_checks();
    endtask

    task automatic send_oversize(input int l);
        @(posedge clk); #1;
        s_valid = 1;
        s_sof = 1;
        s_len = 16'(l);
        s_data = 24'($urandom);
        @(negedge clk);
        chk("ovr_rdy", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 0;
        s_sof = 0;
        m_lerr = 1;
        @(negedge clk);
        chk("ovr_flag", 32'(len_err), 32'd1);
        chk("ovr_idle", 32'(lane_w), 32'(IDLE_W));
        repeat (2) @(posedge clk);
        end_checks();
    endtask

    task automatic send_orphans(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_valid = 1;
            s_sof = 0;
            s_data = 24'($urandom);
            @(negedge clk);
            chk("orphan_rdy", 32'(s_ready), 32'd1);
        end
        @(posedge clk); #1;
        s_valid = 0;
        repeat (2) @(posedge clk);
        end_checks();
    endtask

    task automatic train_idle();
        @(posedge clk); #1;
        train_req = 1;
        @(posedge clk); #1;
        train_req = 0;
        push_train();
        @(negedge clk);
        @(negedge clk);
        chk("tr_first", 32'(lane_w), 32'h0);
        chk("tr_flag", 32'(training), 32'd1);
        repeat (20) @(posedge clk);
        end_checks();
    endtask

    initial begin
        int r;
        int len;
        int k;
        int tr;
        rst = 1;
        train_req = 0;
        s_data = '0;
        s_valid = 0;
        s_sof = 0;
        s_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lane", 32'(lane_w), 32'(IDLE_W));
        chk("rst_training", 32'(training), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_flags", {30'd0, underrun, len_err}, 32'd0);
        chk("rst_sync", 32'(sync_d), 32'h01);
        chk("rst_rdy", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        push_train();
        @(negedge clk);
        for (int i = 0; i < TW; i++) begin
            @(negedge clk);
            chk("train_cnt", 32'(lane_w), 32'(i));
            chk("train_flag", 32'(training), 32'd1);
        end
        @(negedge clk);
        chk("train_end", 32'(lane_w), 32'(IDLE_W));
        chk("train_low", 32'(training), 32'd0);

        fd = '{24'h000001, 24'h000010, 24'h000100};
        send_frame(3, 0, 3, -1, 1);
        send_frame(4, 1, 2, -1, 0);
        send_oversize(300);
        send_oversize(257);
        send_frame(6, 0, 6, 3, 0);
        send_len0();
        send_frame(256, 0, 256, -1, 0);
        send_frame(1, 0, 1, -1, 0);

        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                len = $urandom_range(1, 20);
                tr = (len >= 2 && $urandom_range(0, 2) == 0)
                     ? $urandom_range(1, len - 1) : -1;
                send_frame(len, 0, len, tr, 0);
            end else if (r <= 5) begin
                len = $urandom_range(2, 20);
                k = $urandom_range(1, len - 1);
                tr = (k >= 2 && $urandom_range(0, 1) == 0)
                     ? $urandom_range(1, k - 1) : -1;
                send_frame(len, 1, k, tr, 0);
            end else if (r == 6) begin
                send_oversize($urandom_range(257, 65535));
            end else if (r == 7) begin
                send_orphans($urandom_range(1, 4));
            end else if (r == 8) begin
                send_len0();
            end else begin
                train_idle();
            end
        end

        send_frame(5, 2, 3, -1, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("stream_len", 32'(obs.size()), 32'(expq.size()));
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            chk("stream", obs[i], expq[i]);
        end
        chk("sync", 32'(sync_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
